// File: rtl/queue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : queue_arbiter
// Description : Round-robin arbiter sharing the byte queue's single enqueue
//               port between two deserializer requesters. The winning byte is
//               held on q_data with q_enqueue asserted until the queue length
//               changes (or a dequeue overlaps the enqueue), after which the
//               winner is acknowledged until it drops its valid.
//               Optional feature macro: QARB_TIMEOUT_EN (bounded wait in
//               GRANT with a sticky err flag).
// Revision    : 1.0 - initial release
// ============================================================================
module queue_arbiter #(
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 4,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ack,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ack,
  output logic [DATA_W-1:0] q_data,
  output logic              q_enqueue,
  input  logic              q_dequeue,
  input  logic [LEN_W-1:0]  q_len,
  output logic              err
);

  localparam logic [LEN_W-1:0] c_full_len = LEN_W'(DEPTH);

  // The wait counter is 8 bits wide, so the limit must be representable.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range_check
    $error("queue_arbiter: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  // Registered state
  state_t              r_state;
  logic                r_gnt;       // id of the current/last granted requester
  logic                r_last;      // id of the last requester that was served
  logic [LEN_W-1:0]    r_len_snap;  // queue length captured at grant time
  logic [DATA_W-1:0]   r_q_data;
  logic                r_q_enqueue;
  logic [1:0]          r_ack;       // bit N acknowledges requester N

  // Next-state values
  state_t              w_state_nxt;
  logic                w_gnt_nxt;
  logic                w_last_nxt;
  logic [LEN_W-1:0]    w_len_snap_nxt;
  logic [DATA_W-1:0]   w_q_data_nxt;
  logic                w_q_enqueue_nxt;
  logic [1:0]          w_ack_nxt;

  // Decoded conditions
  logic                w_space;
  logic                w_any_req;
  logic                w_winner;
  logic                w_gnt_valid;
  logic                w_confirm;

  // Room in the queue and pending requests
  assign w_space   = (q_len != c_full_len);
  assign w_any_req = req0_valid | req1_valid;

  // On a tie the requester not served last wins; otherwise the only requester
  assign w_winner  = (req0_valid && req1_valid) ? ~r_last : ~req0_valid;

  // Valid of the requester currently holding the grant
  assign w_gnt_valid = r_gnt ? req1_valid : req0_valid;

  // A length change proves the write landed; a concurrent dequeue can hide
  // that change, so any dequeue seen while granting also counts as proof.
  assign w_confirm = (q_len != r_len_snap) | q_dequeue;

`ifdef QARB_TIMEOUT_EN
  localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);

  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic       r_err;
  logic       w_err_nxt;
`endif

  // Next-state and next-output computation for the arbitration FSM
  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_last_nxt      = r_last;
    w_len_snap_nxt  = r_len_snap;
    w_q_data_nxt    = r_q_data;
    w_q_enqueue_nxt = r_q_enqueue;
    w_ack_nxt       = r_ack;
`ifdef QARB_TIMEOUT_EN
    w_cnt_nxt       = r_cnt;
    w_err_nxt       = r_err;
`endif

    case (r_state)
      IDLE: begin
        if (w_space && w_any_req) begin
          w_gnt_nxt       = w_winner;
          w_q_data_nxt    = w_winner ? req1_data : req0_data;
          w_len_snap_nxt  = q_len;
          w_q_enqueue_nxt = 1'b1;
          w_state_nxt     = GRANT;
`ifdef QARB_TIMEOUT_EN
          w_cnt_nxt       = 8'd0;
`endif
        end
      end

      GRANT: begin
        if (w_confirm) begin
          w_q_enqueue_nxt = 1'b0;
          w_last_nxt      = r_gnt;
          w_ack_nxt       = r_gnt ? 2'b10 : 2'b01;
          w_state_nxt     = ACK;
        end
`ifdef QARB_TIMEOUT_EN
        else if (r_cnt == c_timeout_last) begin
          // Give up on this write; last is untouched so the same
          // requester is granted again on its next attempt.
          w_q_enqueue_nxt = 1'b0;
          w_err_nxt       = 1'b1;
          w_state_nxt     = IDLE;
        end else begin
          w_cnt_nxt       = r_cnt + 8'd1;
        end
`endif
      end

      ACK: begin
        if (!w_gnt_valid) begin
          w_ack_nxt   = 2'b00;
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt     = IDLE;
        w_q_enqueue_nxt = 1'b0;
        w_ack_nxt       = 2'b00;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_gnt       <= 1'b0;
      r_last      <= 1'b1;
      r_len_snap  <= '0;
      r_q_data    <= '0;
      r_q_enqueue <= 1'b0;
      r_ack       <= 2'b00;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_last      <= w_last_nxt;
      r_len_snap  <= w_len_snap_nxt;
      r_q_data    <= w_q_data_nxt;
      r_q_enqueue <= w_q_enqueue_nxt;
      r_ack       <= w_ack_nxt;
    end
  end

`ifdef QARB_TIMEOUT_EN
  // Wait counter and sticky timeout flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= 8'd0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_err <= w_err_nxt;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign q_data    = r_q_data;
  assign q_enqueue = r_q_enqueue;
  assign req0_ack  = r_ack[0];
  assign req1_ack  = r_ack[1];

endmodule
`default_nettype wire

// File: tb/tb_queue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_queue_arbiter
// Description : Directed self-checking bench for queue_arbiter. A behavioural
//               model tracks each transfer (who is granted, which byte, how
//               long it has waited) and is compared with the DUT outputs on
//               every falling edge; literal checks pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_queue_arbiter;

  localparam int DATA_W  = 8;
  localparam int LEN_W   = 4;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 255;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req0_valid = 1'b0;
  logic [DATA_W-1:0] req0_data  = '0;
  logic              req0_ack;
  logic              req1_valid = 1'b0;
  logic [DATA_W-1:0] req1_data  = '0;
  logic              req1_ack;
  logic [DATA_W-1:0] q_data;
  logic              q_enqueue;
  logic              q_dequeue  = 1'b0;
  logic [LEN_W-1:0]  q_len      = '0;
  logic              err;

  int n_cmp = 0;
  int n_bad = 0;

  queue_arbiter #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req0_valid(req0_valid),
    .req0_data (req0_data),
    .req0_ack  (req0_ack),
    .req1_valid(req1_valid),
    .req1_data (req1_data),
    .req1_ack  (req1_ack),
    .q_data    (q_data),
    .q_enqueue (q_enqueue),
    .q_dequeue (q_dequeue),
    .q_len     (q_len),
    .err       (err)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  // busy: 0 = free, 1 = write outstanding, 2 = waiting for winner to let go
  int                busy   = 0;
  int                winner = 0;
  int                served = 1;
  int                waited = 0;
  logic [LEN_W-1:0]  len_at_grant = '0;
  logic              m_enq  = 1'b0;
  logic [DATA_W-1:0] m_data = '0;
  logic [1:0]        m_ack  = 2'b00;
  logic              m_err  = 1'b0;
  logic              vin[2];
  logic [DATA_W-1:0] din[2];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      busy = 0; winner = 0; served = 1; waited = 0; len_at_grant = '0;
      m_enq = 1'b0; m_data = '0; m_ack = 2'b00; m_err = 1'b0;
    end else begin
      vin[0] = req0_valid; vin[1] = req1_valid;
      din[0] = req0_data;  din[1] = req1_data;
      if (busy == 0) begin
        if (int'(q_len) < DEPTH && (vin[0] || vin[1])) begin
          if (vin[0] && vin[1]) winner = 1 - served;
          else                  winner = vin[0] ? 0 : 1;
          m_data = din[winner];
          len_at_grant = q_len;
          waited = 0;
          m_enq = 1'b1;
          busy = 1;
        end
      end else if (busy == 1) begin
        waited++;
        if (q_len != len_at_grant || q_dequeue) begin
          m_enq = 1'b0;
          served = winner;
          m_ack[winner] = 1'b1;
          busy = 2;
        end
`ifdef QARB_TIMEOUT_EN
        else if (waited >= TIMEOUT) begin
          m_enq = 1'b0;
          m_err = 1'b1;
          busy = 0;
        end
`endif
      end else begin
        if (!vin[winner]) begin
          m_ack = 2'b00;
          busy = 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clock) begin
    n_cmp++;
    if ({q_enqueue, req1_ack, req0_ack, err, q_data} !== {m_enq, m_ack, m_err, m_data}) begin
      n_bad++;
      $display("FAIL model_cmp t=%0t: got enq=%b ack1=%b ack0=%b err=%b data=%h, expected enq=%b ack1=%b ack0=%b err=%b data=%h",
               $time, q_enqueue, req1_ack, req0_ack, err, q_data, m_enq, m_ack[1], m_ack[0], m_err, m_data);
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0; q_dequeue = 1'b0; q_len = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    tick(); tick();
    chk("reset_enq",  q_enqueue, 0);
    chk("reset_data", q_data, 8'h00);
    chk("reset_acks", {req1_ack, req0_ack}, 2'b00);
    chk("reset_err",  err, 0);
    reset = 1'b0;

    // Single requester, length change two cycles after the enqueue rises
    tick();
    req0_valid = 1'b1; req0_data = 8'hA5;
    tick();
    chk("single_enq",  q_enqueue, 1);
    chk("single_data", q_data, 8'hA5);
    tick();
    q_len = 4'd1;
    tick();
    chk("single_ack_hi", req0_ack, 1);
    chk("single_enq_lo", q_enqueue, 0);
    req0_valid = 1'b0;
    tick();
    chk("single_ack_lo", req0_ack, 0);

    // Tie from reset: req0 first, then req1, next tie req0 again
    do_reset();
    req0_valid = 1'b1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_data = 8'h22;
    tick();
    chk("tie1_data", q_data, 8'h11);
    q_len = 4'd1;
    tick();
    chk("tie1_ack0", req0_ack, 1);
    req0_valid = 1'b0;
    tick();
    chk("tie1_ack0_lo", req0_ack, 0);
    tick();
    chk("tie2_enq",  q_enqueue, 1);
    chk("tie2_data", q_data, 8'h22);
    q_len = 4'd2;
    tick();
    chk("tie2_ack1", req1_ack, 1);
    req1_valid = 1'b0;
    tick();
    req0_valid = 1'b1; req0_data = 8'h33;
    req1_valid = 1'b1; req1_data = 8'h44;
    tick();
    chk("tie3_data", q_data, 8'h33);
    q_len = 4'd3;
    tick();
    chk("tie3_ack0", req0_ack, 1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // Full queue holds the request back, one free slot grants next cycle
    q_len = 4'd8;
    req1_valid = 1'b1; req1_data = 8'h55;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("full_no_enq", q_enqueue, 0);
    end
    q_len = 4'd7;
    tick();
    chk("full_release_enq",  q_enqueue, 1);
    chk("full_release_data", q_data, 8'h55);
    q_len = 4'd8;
    tick();
    chk("full_release_ack1", req1_ack, 1);
    req1_valid = 1'b0;
    tick();

    // Dequeue overlapping the enqueue, length constant
    q_len = 4'd3;
    req0_valid = 1'b1; req0_data = 8'h66;
    tick();
    chk("deq_enq", q_enqueue, 1);
    tick();
    chk("deq_still_enq", q_enqueue, 1);
    q_dequeue = 1'b1;
    tick();
    chk("deq_ack0", req0_ack, 1);
    q_dequeue = 1'b0;
    req0_valid = 1'b0;
    tick();
    chk("deq_ack0_lo", req0_ack, 0);

    // Reset in the middle of a grant clears everything at once
    req1_valid = 1'b1; req1_data = 8'h77;
    tick();
    chk("midrst_enq_before", q_enqueue, 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_enq",  q_enqueue, 0);
    chk("midrst_data", q_data, 8'h00);
    chk("midrst_acks", {req1_ack, req0_ack}, 2'b00);
    tick();
    req1_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick(); tick();
    chk("midrst_no_ack", {req1_ack, req0_ack}, 2'b00);

`ifdef QARB_TIMEOUT_EN
    // Constant length while granted: give up after TIMEOUT cycles
    begin
      int hi;
      q_len = 4'd3;
      req0_valid = 1'b1; req0_data = 8'h88;
      tick();
      hi = q_enqueue ? 1 : 0;
      while (q_enqueue && hi < 400) begin
        tick();
        if (q_enqueue) hi++;
      end
      chk("timeout_cycles", hi, TIMEOUT);
      chk("timeout_err",    err, 1);
      chk("timeout_no_ack", req0_ack, 0);
      tick();
      chk("timeout_regrant", q_enqueue, 1);
      chk("timeout_regrant_data", q_data, 8'h88);
      q_len = 4'd4;
      tick();
      req0_valid = 1'b0;
      tick(); tick();
    end
`else
    chk("err_tied_low", err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
